// File: rtl/ic_rsp_order_queue_pkg.sv
// Shared definitions for the response-order queue.
// Contents:
//   ptr_width()  - index width for a queue of a given depth (at least 1 bit)
//   cnt_width()  - occupancy width for a queue of a given depth (holds 0..depth)
//   err_cause_t  - individual protocol-error causes, ORed into the sticky flag
package ic_rsp_order_queue_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic multihot;   // more than one request bit set
    logic overflow;   // valid request refused because the queue is full
    logic stray_rsp;  // response bit outside the current grant
  } err_cause_t;

endpackage

// File: rtl/ic_rsp_order_queue_age_timer.sv
// ic_rsp_age_timer: counts how long the oldest queue entry has waited.
// Ports:
//   g_clk, g_resetn - clock, synchronous active-low reset
//   clear           - restart the count (pop, retire or empty queue)
//   enable          - advance the count this cycle
//   expire          - count has reached TIMEOUT_CYCLES-1
// With TIMEOUT_CYCLES == 0 no register is built and expire is tied low.
module ic_rsp_age_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
      logic [AW-1:0] age_reg;

      // expire retires the entry, which clears the age, so the count never
      // runs past TIMEOUT_CYCLES-1.
      always_ff @(posedge g_clk) begin
        if (!g_resetn || clear) begin
          age_reg <= '0;
        end else if (enable) begin
          age_reg <= age_reg + AW'(1);
        end
      end

      assign expire = (age_reg == AW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timer
      logic unused_inputs;
      assign unused_inputs = ^{g_clk, g_resetn, clear, enable};
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ic_rsp_order_queue.sv
// ic_rsp_order_queue: in-order tracker of outstanding interconnect requests.
// Ports:
//   g_clk, g_resetn - clock, synchronous active-low reset
//   requests        - one-hot (or zero) request issued this cycle
//   req_ready       - queue can accept a request (registered state only)
//   responses       - one-hot (or zero) response arriving this cycle
//   response_gnt    - device of the oldest entry; 0 when empty
//   rsp_pop         - granted response consumed this cycle
//   count/empty/full- occupancy
//   timeout         - oldest entry retired by timeout this cycle
//   timeout_dev     - device of the retired entry while timeout is high
//   err_protocol    - sticky protocol error; err_clear clears it (set wins)
module ic_rsp_order_queue
  import ic_rsp_order_queue_pkg::*;
#(
  parameter int ND             = 3,
  parameter int MAX_REQUESTS   = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              g_clk,
  input  logic                              g_resetn,
  input  logic [ND-1:0]                     requests,
  output logic                              req_ready,
  input  logic [ND-1:0]                     responses,
  output logic [ND-1:0]                     response_gnt,
  output logic                              rsp_pop,
  output logic [$clog2(MAX_REQUESTS+1)-1:0] count,
  output logic                              empty,
  output logic                              full,
  output logic                              timeout,
  output logic [ND-1:0]                     timeout_dev,
  output logic                              err_protocol,
  input  logic                              err_clear
);

  localparam int PW = ptr_width(MAX_REQUESTS);
  localparam int CW = cnt_width(MAX_REQUESTS);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_REQUESTS - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(MAX_REQUESTS);

  // Storage is not reset: response_gnt is gated by empty.
  logic [ND-1:0] buffer [MAX_REQUESTS];

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          err_reg;
  logic          req_onehot, push, retire, expire, advance_rd;
  err_cause_t    err_cause;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign req_onehot = (requests != '0) && ((requests & (requests - ND'(1))) == '0);

  assign full      = (count_reg == DEPTH);
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  assign count     = count_reg;

  // A pop in the same cycle does not make room: req_ready looks only at state.
  assign push = req_onehot && req_ready;

  assign response_gnt = empty ? '0 : buffer[rd_ptr_reg];
  assign rsp_pop      = |(responses & response_gnt);

  // A matching response in the expiry cycle wins over the timeout.
  assign retire      = expire && !empty && !rsp_pop;
  assign advance_rd  = rsp_pop || retire;
  assign timeout     = retire;
  assign timeout_dev = retire ? response_gnt : '0;

  assign err_cause.multihot  = (requests != '0) && !req_onehot;
  assign err_cause.overflow  = req_onehot && !req_ready;
  assign err_cause.stray_rsp = |(responses & ~response_gnt);

  assign err_protocol = err_reg;

  ic_rsp_age_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_age_timer (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .clear   (empty || advance_rd),
    .enable  (!empty),
    .expire  (expire)
  );

  always_ff @(posedge g_clk) begin
    if (push) begin
      buffer[wr_ptr_reg] <= requests;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (advance_rd) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(push) - CW'(advance_rd);
      if (|err_cause) begin
        err_reg <= 1'b1;
      end else if (err_clear) begin
        err_reg <= 1'b0;
      end
    end
  end

endmodule
